// File: rtl/count_sched_if.sv
// Bundle between the run scheduler and its requesters plus the shared counter.
// slave is the scheduler side; master is the requester/counter side.
interface count_sched_if #(
   parameter int unsigned WIDTH = 4
);
   logic [1:0]       req;
   logic [WIDTH-1:0] len0;
   logic [WIDTH-1:0] len1;
   logic [WIDTH-1:0] count;
   logic             cnt_en;
   logic             cnt_clr;
   logic [1:0]       gnt;
   logic [1:0]       done;
   logic             busy;

   modport slave (
      input  req, len0, len1, count,
      output cnt_en, cnt_clr, gnt, done, busy
   );

   modport master (
      output req, len0, len1, count,
      input  cnt_en, cnt_clr, gnt, done, busy
   );
endinterface

// File: rtl/count_sched.sv
// Round-robin scheduler granting two requesters timed runs of a shared counter:
// clear, count up to the latched length, then pulse done to the winner.
module count_sched #(
   parameter int unsigned WIDTH = 4
) (
   input logic          clk,
   input logic          rst,
   count_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] len_q, len_d;
   logic [1:0]       gnt_q, gnt_d;
   logic [1:0]       done_q, done_d;
   logic             busy_q, busy_d;
   logic             cnt_clr_q, cnt_clr_d;
   logic             last_q, last_d;
   logic             win;
   logic             req_held;

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      gnt_d    = gnt_q;
      done_d   = '0;
      last_d   = last_q;
      win      = 1'b0;
      req_held = |(bus.req & gnt_q);
      case (state_q)
         IDLE: begin
            if (bus.req != 2'b00) begin
               // both requesting: the one not served last wins
               win     = (bus.req == 2'b11) ? ~last_q : bus.req[1];
               gnt_d   = win ? 2'b10 : 2'b01;
               len_d   = win ? bus.len1 : bus.len0;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            if (!req_held) begin
               state_d = IDLE;
               gnt_d   = '0;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!req_held) begin
               state_d = IDLE;
               gnt_d   = '0;
            end else if (bus.count == len_q) begin
               state_d = DONE;
               done_d  = gnt_q;
            end
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
            last_d  = gnt_q[1];
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
      busy_d    = (state_d != IDLE);
      cnt_clr_d = (state_d == CLEAR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         len_q     <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         busy_q    <= 1'b0;
         cnt_clr_q <= 1'b0;
         last_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         cnt_clr_q <= cnt_clr_d;
         last_q    <= last_d;
      end
   end

   assign bus.cnt_en  = (state_q == RUN) && (bus.count != len_q);
   assign bus.cnt_clr = cnt_clr_q;
   assign bus.gnt     = gnt_q;
   assign bus.done    = done_q;
   assign bus.busy    = busy_q;
endmodule

// File: doc/count_sched.md
COUNT_SCHED -- requirements
Module: count_sched

Parameters
REQ-001 The block SHALL provide parameter WIDTH, default 4, the width of the counter value and of each run length.

Interface
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req  input  2  per-requester run request, level; bit i belongs to requester i.
REQ-005 len0  input  WIDTH  run length for requester 0; sampled only at grant.
REQ-006 len1  input  WIDTH  run length for requester 1; sampled only at grant.
REQ-007 count  input  WIDTH  current value of the shared counter; that counter increments by 1 per clk while its enable is high.
REQ-008 cnt_en  output  1  enable to the shared counter.
REQ-009 cnt_clr  output  1  clear to the shared counter; the counter reads 0 on the cycle after cnt_clr is high.
REQ-010 gnt  output  2  one-hot grant, registered; 2'b00 when no requester is granted.
REQ-011 done  output  2  one-cycle completion pulse to the granted requester, registered.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE, registered.

Function
REQ-013 The FSM SHALL have four states: IDLE, CLEAR, RUN, DONE.
REQ-014 IDLE with req != 0: the arbiter picks a winner, latches its len into len_q, and the FSM moves to CLEAR; gnt goes one-hot from the next cycle.
REQ-015 Arbitration SHALL be round-robin.
- Single request: that requester wins.
- Both requesting: the requester not served last wins.
- last_served SHALL update in DONE only; an aborted run SHALL NOT update it.
REQ-016 CLEAR: cnt_clr = 1 for exactly one cycle, cnt_en = 0; next state is RUN.
REQ-017 RUN: cnt_en SHALL be combinational, equal to (state == RUN) && (count != len_q).
- While count != len_q, the FSM stays in RUN.
- When count == len_q, the FSM moves to DONE.
REQ-018 DONE: done[i] = 1 for exactly one cycle, where i is the granted requester; gnt clears to 0 with done's deassertion; next state is IDLE.
REQ-019 Latency: for a grant decided in cycle c0, the pulses SHALL fall in these cycles:
- cnt_clr: cycle c0+1.
- done: cycle c0+len+3.
- gnt high: cycles c0+1 through c0+len+3 inclusive.
REQ-020 len_q = 0: RUN lasts one cycle, cnt_en is never asserted, and done occurs at c0+3.
REQ-021 Abort: if req of the granted requester drops during CLEAR or RUN, the FSM SHALL go to IDLE next cycle.
- cnt_en is 0 in the abort cycle.
- gnt clears.
- No done pulse.
REQ-022 Requests arriving in CLEAR, RUN or DONE SHALL NOT be granted until the FSM has returned to IDLE; minimum gap between a done and the next grant decision is 1 cycle.
REQ-023 Changes to len0/len1 after grant SHALL NOT affect the current run.
REQ-024 At most one gnt bit and at most one done bit SHALL be high in any cycle; cnt_en and cnt_clr SHALL never be high together.

Reset
REQ-025 rst high at a clock edge SHALL force, from the following cycle:
- state IDLE, last_served = 1.
- gnt = 0, done = 0, busy = 0, cnt_clr = 0, len_q = 0.
- cnt_en = 0.
REQ-026 Reset mid-run SHALL abandon the run with no done pulse; rst takes priority over every other input.

Verification
REQ-027 The bench SHALL cover these scenarios:
- V1: req=01, len0=3 at c0 -> cnt_clr at c1; cnt_en high c2-c4; count 0,1,2,3; done=01 at c6; gnt=01 c1-c6.
- V2: req=11 held, len0=2, len1=1 -> gnt=01 first, done=01; then gnt=10, done=10; then gnt=01 again.
- V3: req=10, len1=0 -> cnt_clr c1, no cnt_en, done=10 at c3.
- V4: req=01, len0=5, req drops at count=2 -> next cycle cnt_en=0, gnt=0, busy=0, no done; the following req=11 grants requester 0 again.
- V5: rst asserted during RUN with count=4 -> next cycle all outputs 0, state IDLE; a subsequent req=11 grants requester 0.
- V6: len0 changed from 3 to 7 during RUN -> done still at c6.
